// File: rtl/symbol_bit_packer.sv
// symbol_bit_packer: repacks 1/2/3-bit hard-decision symbols into MSB-first bytes, zero-padding and tagging each frame's last byte
module symbol_bit_packer (
    input  logic       iclk,
    input  logic       ireset,
    input  logic [1:0] i_mod,
    input  logic       i_valid,
    input  logic [2:0] i_symbol,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    input  logic       i_ready
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t     state, state_nx;
    logic [9:0] acc, acc_nx, wide, sym;
    logic [3:0] cnt, cnt_nx, sz, n, sh;
    logic [1:0] mod_q, mod_nx, eff_mod;
    logic       frame_active, act_nx, valid_nx, last_nx, free, accept;
    logic [7:0] data_nx;
    assign free    = !o_valid || i_ready;
    assign o_ready = !ireset && state == RUN && free;
    assign accept  = i_valid && o_ready;
    assign eff_mod = frame_active ? mod_q : i_mod;
    assign sz      = eff_mod == 2'd1 ? 4'd2 : eff_mod == 2'd2 ? 4'd3 : 4'd1;
    assign sym     = eff_mod == 2'd1 ? {8'd0, i_symbol[1:0]} : eff_mod == 2'd2 ? {7'd0, i_symbol} : {9'd0, i_symbol[0]};
    // held bits sit right-aligned in acc, earliest bit highest
    assign wide    = (acc << sz) | sym;
    assign n       = cnt + sz;
    assign sh      = n - 4'd8;
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        mod_nx   = mod_q;
        act_nx   = frame_active;
        valid_nx = o_valid && !i_ready;
        data_nx  = o_data;
        last_nx  = o_last;
        if (state == FLUSH && free) begin
            valid_nx = 1'b1;
            data_nx  = 8'(acc << (4'd8 - cnt));
            last_nx  = 1'b1;
            cnt_nx   = 4'd0;
            acc_nx   = 10'd0;
            state_nx = RUN;
        end else if (accept) begin
            mod_nx = eff_mod;
            act_nx = !i_last;
            if (n >= 4'd8) begin
                valid_nx = 1'b1;
                data_nx  = 8'(wide >> sh);
                last_nx  = i_last && n == 4'd8;
                cnt_nx   = last_nx ? 4'd0 : sh;
                acc_nx   = wide & ~(10'h3ff << sh);
                state_nx = i_last && n > 4'd8 ? FLUSH : RUN;
            end else if (i_last) begin
                valid_nx = 1'b1;
                data_nx  = 8'(wide << (4'd8 - n));
                last_nx  = 1'b1;
                cnt_nx   = 4'd0;
                acc_nx   = 10'd0;
            end else begin
                cnt_nx = n;
                acc_nx = wide;
            end
        end
    end
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state        <= RUN;
            acc          <= 10'd0;
            cnt          <= 4'd0;
            mod_q        <= 2'd0;
            frame_active <= 1'b0;
            o_valid      <= 1'b0;
            o_data       <= 8'd0;
            o_last       <= 1'b0;
        end else begin
            state        <= state_nx;
            acc          <= acc_nx;
            cnt          <= cnt_nx;
            mod_q        <= mod_nx;
            frame_active <= act_nx;
            o_valid      <= valid_nx;
            o_data       <= data_nx;
            o_last       <= last_nx;
        end
    end
endmodule
